// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier control slice.
// Holds the one-hot state encoding, the recoded-op struct and the default operand width.
// Imported by booth_r4_recode and booth_r4_ctrl.
package booth_pkg;

  localparam int WIDTH_DEF = 8;

  // One-hot so that every strobe decodes from a single state bit.
  typedef enum logic [8:0] {
    IDLE   = 9'b0_0000_0001,
    LOAD_M = 9'b0_0000_0010,
    LOAD_Q = 9'b0_0000_0100,
    DECODE = 9'b0_0000_1000,
    ADD    = 9'b0_0001_0000,
    SHIFT  = 9'b0_0010_0000,
    OUT_A  = 9'b0_0100_0000,
    OUT_Q  = 9'b0_1000_0000,
    DONE   = 9'b1_0000_0000
  } state_e;

  // nz: an add/subtract is needed; sub: subtract M; x2: use 2M instead of M.
  typedef struct packed {
    logic nz;
    logic sub;
    logic x2;
  } op_t;

endpackage

// File: rtl/booth_r4_recode.sv
// Radix-4 Booth recoder: maps the {q[1], q[0], q[-1]} triplet to {nz, sub, x2}.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the input continuously.
// Ports: q_bits (triplet in), op (recoded operation out).
module booth_r4_recode
  import booth_pkg::*;
(
  input  logic [2:0] q_bits,
  output op_t        op
);

  always_comb begin
    op = '0;
    case (q_bits)
      3'b001, 3'b010: begin op.nz = 1'b1; op.sub = 1'b0; op.x2 = 1'b0; end  // +M
      3'b011:         begin op.nz = 1'b1; op.sub = 1'b0; op.x2 = 1'b1; end  // +2M
      3'b100:         begin op.nz = 1'b1; op.sub = 1'b1; op.x2 = 1'b1; end  // -2M
      3'b101, 3'b110: begin op.nz = 1'b1; op.sub = 1'b1; op.x2 = 1'b0; end  // -M
      default:        op = '0;                                              // 000 / 111: no-op
    endcase
  end

endmodule

// File: rtl/booth_r4_ctrl.sv
// Radix-4 Booth multiplier control sequencer: drives datapath strobes c0..c7 from a one-hot FSM.
// Latency: start edge to done pulse is 2 + 2*ITER + 3 cycles minimum, 2 + 3*ITER + 3 maximum.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
// Ports: clk, reset (async active-low), start, q_bits in; c0..c7, c4/cx2 add modifiers, busy, done out.
module booth_r4_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] q_bits,
  output logic       c0,
  output logic       c1,
  output logic       c2,
  output logic       c3,
  output logic       c4,
  output logic       cx2,
  output logic       c5,
  output logic       c6,
  output logic       c7,
  output logic       busy,
  output logic       done
);

  localparam int              ITER     = WIDTH / 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_t              op_q, op_d;
  op_t              op_rec;

  booth_r4_recode u_recode (
    .q_bits (q_bits),
    .op     (op_rec)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // Outputs depend on state_q and the latched op only, never on live inputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    c0      = 1'b0;
    c1      = 1'b0;
    c2      = 1'b0;
    c3      = 1'b0;
    c4      = 1'b0;
    cx2     = 1'b0;
    c5      = 1'b0;
    c6      = 1'b0;
    c7      = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD_M;
      end
      LOAD_M: begin
        busy    = 1'b1;
        c2      = 1'b1;
        state_d = LOAD_Q;
      end
      LOAD_Q: begin
        busy    = 1'b1;
        c1      = 1'b1;
        c0      = 1'b1;
        cnt_d   = '0;
        state_d = DECODE;
      end
      DECODE: begin
        busy    = 1'b1;
        op_d    = op_rec;
        state_d = op_rec.nz ? ADD : SHIFT;
      end
      ADD: begin
        busy    = 1'b1;
        c3      = 1'b1;
        c4      = op_q.sub;
        cx2     = op_q.x2;
        state_d = SHIFT;
      end
      SHIFT: begin
        busy    = 1'b1;
        c5      = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (cnt_q == CNT_LAST) ? OUT_A : DECODE;
      end
      OUT_A: begin
        busy    = 1'b1;
        c6      = 1'b1;
        state_d = OUT_Q;
      end
      OUT_Q: begin
        busy    = 1'b1;
        c7      = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        // Corrupted encoding: recover to IDLE with all strobes low.
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_r4_ctrl.sv
module tb_booth_r4_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] q_in;
  logic       c0, c1, c2, c3, c4, cx2, c5, c6, c7, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  booth_r4_ctrl #(.WIDTH(8), .CNT_W(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .q_bits (q_in),
    .c0     (c0),
    .c1     (c1),
    .c2     (c2),
    .c3     (c3),
    .c4     (c4),
    .cx2    (cx2),
    .c5     (c5),
    .c6     (c6),
    .c7     (c7),
    .busy   (busy),
    .done   (done)
  );

  // Stimulus selection for q_bits: forced value (optionally inverted while in ADD,
  // so a design that reads live q_bits in ADD gives the wrong c4/cx2) or the datapath model.
  logic       closed;
  logic       flip;
  logic [2:0] force_q;
  logic [7:0] m_op, q_op;

  // Behavioural datapath: A is 10 bits wide so that +/-2M never overflows.
  logic signed [9:0] a_m;
  logic        [7:0] q_m, m_m;
  logic              qm1_m;
  logic signed [9:0] m_ext, addend;
  logic        [7:0] inbus, outbus;

  assign m_ext  = {{2{m_m[7]}}, m_m};
  assign addend = cx2 ? (m_ext <<< 1) : m_ext;
  assign inbus  = c2 ? m_op : q_op;
  assign outbus = c6 ? a_m[7:0] : (c7 ? q_m : 8'h00);
  assign q_in   = closed ? {q_m[1], q_m[0], qm1_m}
                         : ((flip && c3) ? ~force_q : force_q);

  always @(posedge clk) begin
    if (c0) begin a_m <= '0; qm1_m <= 1'b0; end
    if (c1) q_m <= inbus;
    if (c2) m_m <= inbus;
    if (c3) a_m <= c4 ? a_m - addend : a_m + addend;
    if (c5) begin
      {a_m, q_m} <= $signed({a_m, q_m}) >>> 2;
      qm1_m      <= q_m[1];
    end
  end

  // Monitor: samples 1 time unit after every rising edge.
  int cyc, n_c2, n_c10, n_c3, n_sub, n_x2, n_c5, n_c6, n_c7, n_busy, n_done, n_excl;
  int cyc_c2, cyc_c1, cyc_c6, cyc_c7, cyc_done;
  logic [7:0] out_a, out_q;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (c2) begin n_c2++; cyc_c2 = cyc; end
    if (c1 && c0) begin n_c10++; cyc_c1 = cyc; end
    if (c1 != c0) n_excl++;
    if (c3) begin n_c3++; if (c4) n_sub++; if (cx2) n_x2++; end
    if (c5) n_c5++;
    if (c6) begin n_c6++; cyc_c6 = cyc; out_a = outbus; end
    if (c7) begin n_c7++; cyc_c7 = cyc; out_q = outbus; end
    if (busy) n_busy++;
    if (done) begin n_done++; cyc_done = cyc; end
    if ((int'(c0 | c1) + int'(c2) + int'(c3) + int'(c5) + int'(c6) + int'(c7)) > 1) n_excl++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counters();
    cyc = 0; n_c2 = 0; n_c10 = 0; n_c3 = 0; n_sub = 0; n_x2 = 0; n_c5 = 0;
    n_c6 = 0; n_c7 = 0; n_busy = 0; n_done = 0; n_excl = 0;
    cyc_c2 = 0; cyc_c1 = 0; cyc_c6 = 0; cyc_c7 = 0; cyc_done = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      if (n_done > 0) break;
      @(negedge clk);
    end
    if (n_done == 0) check_eq("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  // Called at a negedge: pulse start for one cycle, then wait for done.
  task automatic run_op();
    clear_counters();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
  endtask

  logic [2:0] exp_op [8] = '{3'b000, 3'b100, 3'b100, 3'b101, 3'b111, 3'b110, 3'b110, 3'b000};

  initial begin
    reset = 1'b0; start = 1'b0; closed = 1'b0; flip = 1'b1; force_q = 3'b000;
    m_op = 8'h00; q_op = 8'h00;
    a_m = '0; q_m = '0; m_m = '0; qm1_m = 1'b0;
    out_a = '0; out_q = '0;
    clear_counters();
    #1;
    check_eq("reset_outputs", {c0, c1, c2, c3, c4, cx2, c5, c6, c7, busy, done}, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("idle_outputs", {c0, c1, c2, c3, c4, cx2, c5, c6, c7, busy, done}, 0);

    // Recode sweep plus sequence structure for every triplet.
    for (int qb = 0; qb < 8; qb++) begin
      int lat;
      force_q = 3'(qb);
      lat = exp_op[qb][2] ? 17 : 13;
      run_op();
      check_eq($sformatf("q%0d_latency", qb), cyc_done, lat);
      check_eq($sformatf("q%0d_c3_cnt", qb), n_c3, exp_op[qb][2] ? 4 : 0);
      check_eq($sformatf("q%0d_c4_cnt", qb), n_sub, exp_op[qb][1] ? 4 : 0);
      check_eq($sformatf("q%0d_cx2_cnt", qb), n_x2, exp_op[qb][0] ? 4 : 0);
      check_eq($sformatf("q%0d_c5_cnt", qb), n_c5, 4);
      check_eq($sformatf("q%0d_c2_cyc", qb), cyc_c2, 1);
      check_eq($sformatf("q%0d_c1c0_cyc", qb), cyc_c1, 2);
      check_eq($sformatf("q%0d_c6_cyc", qb), cyc_c6, lat - 2);
      check_eq($sformatf("q%0d_c7_cyc", qb), cyc_c7, lat - 1);
      check_eq($sformatf("q%0d_busy_cnt", qb), n_busy, lat);
      check_eq($sformatf("q%0d_strobe_cnt", qb), n_c2 + n_c10 + n_c6 + n_c7 + n_done, 5);
      check_eq($sformatf("q%0d_exclusive", qb), n_excl, 0);
    end
    flip = 1'b0;

    // start raised during the 2nd SHIFT and held through DONE.
    force_q = 3'b000;
    clear_counters();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && n_c5 < 2; i++) @(negedge clk);
    start = 1'b1;
    wait_done();   // returns at the negedge in the IDLE cycle after DONE
    check_eq("held_start_latency", cyc_done, 13);
    check_eq("held_start_c5_cnt", n_c5, 4);
    check_eq("held_start_done_cnt", n_done, 1);
    clear_counters();
    @(negedge clk);
    start = 1'b0;
    check_eq("restart_c2", c2, 1);
    wait_done();
    check_eq("restart_latency", cyc_done, 13);
    check_eq("restart_c5_cnt", n_c5, 4);

    // Reset asserted during the 3rd SHIFT.
    clear_counters();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && !(c5 && n_c5 == 3); i++) @(negedge clk);
    check_eq("third_shift_seen", n_c5, 3);
    reset = 1'b0;
    #1;
    check_eq("midop_reset_outputs", {c0, c1, c2, c3, c4, cx2, c5, c6, c7, busy, done}, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) @(negedge clk);
    check_eq("midop_reset_no_done", n_done, 0);
    check_eq("midop_reset_idle", busy, 0);
    run_op();
    check_eq("post_reset_latency", cyc_done, 13);
    check_eq("post_reset_c5_cnt", n_c5, 4);

    // Closed loop against the datapath model.
    closed = 1'b1;
    m_op = 8'h05; q_op = 8'h03;
    run_op();
    check_eq("mul_5x3_a", out_a, 8'h00);
    check_eq("mul_5x3_q", out_q, 8'h0F);
    m_op = 8'hF9; q_op = 8'h06;
    run_op();
    check_eq("mul_m7x6_a", out_a, 8'hFF);
    check_eq("mul_m7x6_q", out_q, 8'hD6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_r4_ctrl.md
Name: booth_r4_ctrl

Overview:
- Control sequencer for the radix-4 Booth multiplier. It reads the recoding triplet shifted out at the bottom of the Q register, and issues the load, clear, add/subtract, shift and output strobes to the datapath.
- Datapath: A accumulator, Q register with its q[-1] extension bit, M register, and an adder with 1x/2x select.
- The block sits between the top-level start/done interface and the datapath control inputs c0..c7.

Parameters:
- WIDTH, 8, operand width in bits (even); iteration count ITER = WIDTH/2.
- CNT_W, 2, iteration counter width; must satisfy 2**CNT_W >= ITER.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a multiplication; sampled in IDLE only.
- q_bits  input  3  {q[1], q[0], q[-1]} from the Q register.
- c0  output  1  clear A and q[-1].
- c1  output  1  load Q[7:0] from inbus.
- c2  output  1  load M from inbus.
- c3  output  1  A <= A +/- (M or 2M).
- c4  output  1  subtract select; valid while c3=1.
- cx2  output  1  2M select; valid while c3=1.
- c5  output  1  arithmetic right shift of A:Q by 2.
- c6  output  1  drive A onto outbus.
- c7  output  1  drive Q[7:0] onto outbus.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at end of operation.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, op register=0, all outputs 0.
- Moore outputs: every output is decoded from the one-hot state register only, so each strobe lasts exactly one clk cycle.
- IDLE: start=1 at a rising edge moves to LOAD_M; otherwise stay in IDLE.
- LOAD_M: c2=1; next state is LOAD_Q.
- LOAD_Q: c1=1 and c0=1 in the same cycle; counter <= 0; next state is DECODE.
- DECODE: latch the recoded op from q_bits into the op register.
  - Recode table (q_bits -> op): 000 -> 0; 001 -> +M; 010 -> +M; 011 -> +2M; 100 -> -2M; 101 -> -M; 110 -> -M; 111 -> 0.
  - Non-zero op: next state is ADD. Zero op: next state is SHIFT.
- ADD: c3=1, with c4 and cx2 taken from the latched op (not from live q_bits); next state is SHIFT.
- SHIFT: c5=1; counter increments.
  - If counter was ITER-1: next state is OUT_A.
  - Otherwise: next state is DECODE.
- OUT_A: c6=1; next state is OUT_Q.
- OUT_Q: c7=1; next state is DONE.
- DONE: done=1, busy=1; next state is IDLE.
- Latency, counted in cycles from the start-sampling edge to the done-high cycle, inclusive:
  - Minimum (no ADD states): 2 + 2*ITER + 3 = 13 for WIDTH=8.
  - Maximum (ADD every iteration): 2 + 3*ITER + 3 = 17 for WIDTH=8.
- start while busy=1 is ignored, including start held high across DONE.
- start still high in the first IDLE cycle after DONE begins a new operation.
- Exactly one of c0/c1 (as a pair), c2, c3, c5, c6, c7 is active in any cycle; c0 and c1 never overlap c5.
- Reset mid-operation: outputs drop to 0 immediately and the operation is abandoned; no done pulse is produced.
- Illegal or unreachable state encodings: next state is IDLE, all outputs 0.

Decomposition:
- Shared package booth_pkg holds:
  - state encoding constants: IDLE, LOAD_M, LOAD_Q, DECODE, ADD, SHIFT, OUT_A, OUT_Q, DONE;
  - op encoding {nz, sub, x2};
  - WIDTH default.
- One combinational sub-module, booth_r4_recode: q_bits[2:0] -> {nz, sub, x2}.
- booth_r4_ctrl instantiates booth_r4_recode and holds the state register, counter and op register.

Test Plan:
- Recode sweep: force each q_bits value 000..111 in DECODE -> in ADD (or skipped ADD), required {c3, c4, cx2} are 0xx, 100, 100, 101, 111, 110, 110, 0xx.
- q_bits=000 held, start pulse -> c2, then c1+c0, then c5 pulsed exactly 4 times with no c3, then c6, c7, done; done asserted 13 cycles after start.
- q_bits=011 held -> 4 ADD cycles, each with c4=0 and cx2=1; done at cycle 17; busy high from LOAD_M through DONE.
- start asserted again during the 2nd SHIFT and held through DONE -> first operation unaffected (4 c5 pulses); a second operation starts from IDLE immediately after DONE.
- reset low during the 3rd SHIFT -> all outputs 0 in the same cycle, no done pulse; after release, a new start runs a full 4 iterations.
- Closed loop with a behavioural datapath model:
  - M=8'h05, Q=8'h03 -> outbus A=8'h00, then Q=8'h0F.
  - M=8'hF9, Q=8'h06 -> outbus A=8'hFF, then Q=8'hD6 (-42).
